// File: rtl/bus_dev_fifo.sv
`default_nettype none
// ============================================================================
// bus_dev_fifo : per-terminal first-word-fall-through transmit FIFO with
//                destination screening and overflow/underflow reporting.
// Revision     : 1.0
// ============================================================================
module bus_dev_fifo #(
  parameter int         PCKG_SZ = 16,
  parameter int         DEPTH   = 8,
  parameter int         DRVRS   = 4,
  parameter int         ID      = 0,
  parameter logic [7:0] BCAST   = 8'hFF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [PCKG_SZ-1:0]         D_push,
  input  logic                       pop,
  output logic [PCKG_SZ-1:0]         D_pop,
  output logic                       pndng,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       drop,
  output logic                       bad_dst,
  output logic                       udf,
  output logic [7:0]                 ovf_cnt
);

  localparam int              c_aw    = $clog2(DEPTH);
  localparam int              c_cw    = $clog2(DEPTH+1);
  localparam logic [7:0]      c_id    = ID[7:0];
  localparam logic [7:0]      c_drvrs = DRVRS[7:0];
  localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);
  localparam logic [c_cw-1:0] c_one   = c_cw'(1);
  localparam logic [c_aw-1:0] c_pinc  = c_aw'(1);

  logic [PCKG_SZ-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]    r_wr_ptr, r_rd_ptr;
  logic [c_cw-1:0]    r_count, w_count_nxt;
  logic               r_pndng, r_full, r_drop, r_bad_dst, r_udf;
  logic [7:0]         r_ovf_cnt;

  logic [7:0] w_dst;
  logic       w_legal_dst, w_legal_push, w_bad_push;
  logic       w_do_push, w_do_pop, w_ovf, w_udf;

  assign w_dst        = D_push[PCKG_SZ-1 -: 8];
  assign w_legal_dst  = ((w_dst < c_drvrs) || (w_dst == BCAST)) && (w_dst != c_id);
  assign w_legal_push = push && w_legal_dst;
  assign w_bad_push   = push && !w_legal_dst;

  // When full, a concurrent pop frees the slot the push lands in.
  assign w_do_pop  = pop && r_pndng;
  assign w_do_push = w_legal_push && (!r_full || pop);
  assign w_ovf     = w_legal_push && r_full && !pop;
  assign w_udf     = pop && !r_pndng;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_nxt = r_count + c_one;
      2'b01:   w_count_nxt = r_count - c_one;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_pndng   <= 1'b0;
      r_full    <= 1'b0;
      r_drop    <= 1'b0;
      r_bad_dst <= 1'b0;
      r_udf     <= 1'b0;
      r_ovf_cnt <= 8'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_pinc;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_pinc;
      r_count   <= w_count_nxt;
      r_pndng   <= (w_count_nxt != '0);
      r_full    <= (w_count_nxt == c_depth);
      r_drop    <= w_bad_push || w_ovf;
      r_bad_dst <= w_bad_push;
      r_udf     <= w_udf;
      if (w_ovf && (r_ovf_cnt != 8'hFF)) r_ovf_cnt <= r_ovf_cnt + 8'd1;
    end
  end

  // Storage needs no reset; empty-state output is forced to zero below.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= D_push;
  end

  assign D_pop   = r_pndng ? r_mem[r_rd_ptr] : '0;
  assign pndng   = r_pndng;
  assign full    = r_full;
  assign count   = r_count;
  assign drop    = r_drop;
  assign bad_dst = r_bad_dst;
  assign udf     = r_udf;
  assign ovf_cnt = r_ovf_cnt;

endmodule
`default_nettype wire

// File: doc/bus_dev_fifo.md
Name: bus_dev_fifo

Overview:
- Per-terminal transmit FIFO between a terminal's Driver_Monitor agent and the shared bus.
- The driver pushes packets; the bus controller pops them while pndng is high.
- Head data is first-word-fall-through, so the bus samples D_pop in the same cycle it asserts pop.
- Also screens illegal destinations and counts overflow/underflow events for the scoreboard.

Parameters:
- PCKG_SZ, 16, packet width in bits; bits [PCKG_SZ-1:PCKG_SZ-8] hold the destination ID.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- DRVRS, 4, number of terminals on the bus; legal unicast IDs are 0..DRVRS-1.
- ID, 0, this terminal's own ID.
- BCAST, 8'hFF, broadcast destination ID.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: reset, asynchronous, active-low.
- push, input, 1: driver write strobe.
- D_push, input, PCKG_SZ: packet written on push.
- pop, input, 1: bus read strobe.
- D_pop, output, PCKG_SZ: head packet, valid while pndng=1.
- pndng, output, 1: FIFO not empty.
- full, output, 1: count==DEPTH.
- count, output, $clog2(DEPTH+1): occupied entries.
- drop, output, 1: one-cycle pulse; a push was discarded.
- bad_dst, output, 1: one-cycle pulse; the discard was caused by an illegal destination.
- udf, output, 1: one-cycle pulse; pop while empty.
- ovf_cnt, output, 8: saturating count of drops caused by full.

Behaviour:
- Reset (rst=0, asynchronous):
  - Pointers and count = 0.
  - pndng, full, drop, bad_dst, udf = 0; ovf_cnt = 0.
  - D_pop = 0; storage contents are don't-care.
  - Release is synchronous to the next clk edge.
- Destination check on push: dst = D_push[PCKG_SZ-1:PCKG_SZ-8].
  - Legal if dst < DRVRS or dst == BCAST, and dst != ID (a terminal never addresses itself).
  - Illegal push: not stored; drop=1 and bad_dst=1 next cycle; ovf_cnt unchanged.
- Write: a legal push with count<DEPTH stores at wr_ptr; wr_ptr and count update at the edge.
  - Data is visible on D_pop the next cycle if the FIFO was empty (1-cycle push-to-pndng latency).
- Read: pop with count>0 advances rd_ptr at the edge; D_pop shows the next entry the following cycle.
  - D_pop = 0 when empty.
- Simultaneous legal push and pop:
  - Empty: push is stored, pop is ignored, udf=1.
  - 0<count<DEPTH: both occur; count unchanged.
  - Full: both occur; the new packet is written into the slot freed by the pop; no drop; count stays DEPTH.
- Full, legal push, no pop: packet discarded; drop=1; ovf_cnt+1, saturating at 255.
- Pop when empty (no push): udf=1; pointers unchanged.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap DEPTH-1 to 0; order is preserved across wrap.
- Flag derivation:
  - pndng = (count!=0) and full = (count==DEPTH), both registered with count; no combinational path from push/pop.
  - drop, bad_dst, udf are registered and high exactly one cycle per event.
- Reset mid-operation: all content is lost immediately; pndng falls asynchronously with rst.
- Throughput: one push and one pop per cycle sustained; no bubbles.

Test Plan:
- Reset, then push 3 packets {8'h01,8'hAA}, {8'h02,8'hBB}, {8'hFF,8'hCC} (ID=0) on consecutive cycles -> pndng=1 one cycle after the first push; count=3; popping 3 times yields D_pop 16'h01AA, 16'h02BB, 16'hFFCC in order; then pndng=0, D_pop=0.
- Push 9 legal packets with no pop (DEPTH=8) -> full=1 at count=8; 9th push gives drop=1 for one cycle, ovf_cnt=1; the 8 stored packets pop out in order.
- With full=1, push and pop in the same cycle -> no drop; count stays 8; popped head = oldest entry; new packet becomes the last entry.
- Push packets with dst=8'h00 (self), 8'h04 (≥DRVRS) and 8'h05 -> each gives drop=1 and bad_dst=1; count=0; ovf_cnt=0.
- Pop on empty FIFO, and push+pop together on empty -> both give udf=1; in the second case count=1 and D_pop = the pushed packet.
- Fill to 5 entries, pulse rst low mid-cycle -> pndng, full, count drop to 0 without waiting for clk; ovf_cnt=0; the next push after release is stored at entry 0.
- Additional: 20 push/pop streams covering wrap-around, checked against a reference queue model.
